// File: rtl/mspu_pkg.sv
// Shared types for the memory-access stage: FSM states, access-size encodings
// and the alignment rule used by the lane steering logic.
package mspu_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp
    } mem_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'd0,
        SZ_HALF    = 2'd1,
        SZ_WORD    = 2'd2,
        SZ_ILLEGAL = 2'd3
    } mem_size_e;

    localparam int unsigned TmoW = 8;

    // The illegal size encoding is treated as a misaligned access so it never reaches the bus.
    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] off);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = off[0];
            SZ_WORD: mis = (off != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for stores and shift/extension for loads.
module lsu_align
    import mspu_pkg::*;
(
    input  mem_size_e   st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_lanes,
    output logic        st_misaligned,
    input  mem_size_e   ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shift;

    always_comb begin
        st_be    = 4'b0000;
        st_lanes = st_wdata;
        unique case (st_size)
            SZ_BYTE: begin
                st_be    = 4'b0001 << st_off;
                st_lanes = {4{st_wdata[7:0]}};
            end
            SZ_HALF: begin
                st_be    = 4'b0011 << st_off;
                st_lanes = {2{st_wdata[15:0]}};
            end
            SZ_WORD: begin
                st_be    = 4'b1111;
                st_lanes = st_wdata;
            end
            default: begin
                st_be    = 4'b0000;
                st_lanes = st_wdata;
            end
        endcase
        st_misaligned = is_misaligned(st_size, st_off);
    end

    always_comb begin
        ld_shift = ld_rdata >> {ld_off, 3'b000};
        unique case (ld_size)
            SZ_BYTE: ld_data = {{24{~ld_unsigned & ld_shift[7]}}, ld_shift[7:0]};
            SZ_HALF: ld_data = {{16{~ld_unsigned & ld_shift[15]}}, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues one data-memory transaction at a time,
// stalls execute while busy, and produces the writeback strobe and error pulses.
module mem_access
    import mspu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run_in,
    input  logic        mem_to_reg_in,
    input  logic        we_in,
    input  logic        re_in,
    input  logic        reg_we_in,
    input  logic [1:0]  bytes_in,
    input  logic        unsigned_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] wdata_in,
    input  logic [4:0]  rd_in,
    output logic        stall,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misalign_err,
    output logic        bus_err
);

    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

    mem_state_e      state_q, state_d;
    logic [TmoW-1:0] tmo_q, tmo_d;

    logic        dm_req_q, dm_req_d;
    logic        dm_we_q, dm_we_d;
    logic [31:0] dm_addr_q, dm_addr_d;
    logic [31:0] dm_wdata_q, dm_wdata_d;
    logic [3:0]  dm_be_q, dm_be_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        misalign_q, misalign_d;
    logic        bus_err_q, bus_err_d;

    // Context of the in-flight access, needed when the response arrives.
    logic        op_load_q, op_load_d;
    logic        op_reg_we_q, op_reg_we_d;
    logic [4:0]  op_rd_q, op_rd_d;
    mem_size_e   op_size_q, op_size_d;
    logic        op_unsigned_q, op_unsigned_d;
    logic [1:0]  op_off_q, op_off_d;

    mem_size_e   in_size;
    logic [3:0]  st_be;
    logic [31:0] st_lanes;
    logic        st_misaligned;
    logic [31:0] ld_data;
    logic        is_mem_op;
    logic        unused_in;

    assign in_size   = mem_size_e'(bytes_in);
    assign is_mem_op = we_in | re_in;
    // Register-file source selection happens downstream; the bit is carried for interface parity.
    assign unused_in = mem_to_reg_in;

    lsu_align u_lsu_align (
        .st_size       (in_size),
        .st_off        (alu_result_in[1:0]),
        .st_wdata      (wdata_in),
        .st_be         (st_be),
        .st_lanes      (st_lanes),
        .st_misaligned (st_misaligned),
        .ld_size       (op_size_q),
        .ld_off        (op_off_q),
        .ld_unsigned   (op_unsigned_q),
        .ld_rdata      (dm_rdata),
        .ld_data       (ld_data)
    );

    always_comb begin
        state_d       = state_q;
        tmo_d         = tmo_q;
        dm_req_d      = dm_req_q;
        dm_we_d       = dm_we_q;
        dm_addr_d     = dm_addr_q;
        dm_wdata_d    = dm_wdata_q;
        dm_be_d       = dm_be_q;
        wb_valid_d    = 1'b0;
        wb_rd_d       = wb_rd_q;
        wb_data_d     = wb_data_q;
        misalign_d    = 1'b0;
        bus_err_d     = 1'b0;
        op_load_d     = op_load_q;
        op_reg_we_d   = op_reg_we_q;
        op_rd_d       = op_rd_q;
        op_size_d     = op_size_q;
        op_unsigned_d = op_unsigned_q;
        op_off_d      = op_off_q;

        unique case (state_q)
            StIdle: begin
                if (run_in) begin
                    if (!is_mem_op) begin
                        wb_valid_d = reg_we_in;
                        wb_rd_d    = rd_in;
                        wb_data_d  = alu_result_in;
                    end else if (st_misaligned) begin
                        misalign_d = 1'b1;
                    end else begin
                        state_d       = StReq;
                        tmo_d         = '0;
                        dm_req_d      = 1'b1;
                        dm_we_d       = we_in;
                        dm_addr_d     = {alu_result_in[31:2], 2'b00};
                        dm_be_d       = st_be;
                        dm_wdata_d    = st_lanes;
                        op_load_d     = ~we_in;
                        op_reg_we_d   = reg_we_in;
                        op_rd_d       = rd_in;
                        op_size_d     = in_size;
                        op_unsigned_d = unsigned_in;
                        op_off_d      = alu_result_in[1:0];
                    end
                end
            end
            StReq: begin
                if (dm_ack) begin
                    state_d  = StResp;
                    tmo_d    = '0;
                    dm_req_d = 1'b0;
                    dm_we_d  = 1'b0;
                    if (op_load_q) begin
                        wb_valid_d = op_reg_we_q;
                        wb_rd_d    = op_rd_q;
                        wb_data_d  = ld_data;
                    end
                end else if (tmo_q == TmoLast) begin
                    state_d   = StIdle;
                    tmo_d     = '0;
                    dm_req_d  = 1'b0;
                    dm_we_d   = 1'b0;
                    bus_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            tmo_q         <= '0;
            dm_req_q      <= 1'b0;
            dm_we_q       <= 1'b0;
            dm_addr_q     <= '0;
            dm_wdata_q    <= '0;
            dm_be_q       <= '0;
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= '0;
            wb_data_q     <= '0;
            misalign_q    <= 1'b0;
            bus_err_q     <= 1'b0;
            op_load_q     <= 1'b0;
            op_reg_we_q   <= 1'b0;
            op_rd_q       <= '0;
            op_size_q     <= SZ_BYTE;
            op_unsigned_q <= 1'b0;
            op_off_q      <= '0;
        end else begin
            state_q       <= state_d;
            tmo_q         <= tmo_d;
            dm_req_q      <= dm_req_d;
            dm_we_q       <= dm_we_d;
            dm_addr_q     <= dm_addr_d;
            dm_wdata_q    <= dm_wdata_d;
            dm_be_q       <= dm_be_d;
            wb_valid_q    <= wb_valid_d;
            wb_rd_q       <= wb_rd_d;
            wb_data_q     <= wb_data_d;
            misalign_q    <= misalign_d;
            bus_err_q     <= bus_err_d;
            op_load_q     <= op_load_d;
            op_reg_we_q   <= op_reg_we_d;
            op_rd_q       <= op_rd_d;
            op_size_q     <= op_size_d;
            op_unsigned_q <= op_unsigned_d;
            op_off_q      <= op_off_d;
        end
    end

    assign stall        = (state_q != StIdle);
    assign dm_req       = dm_req_q;
    assign dm_we        = dm_we_q;
    assign dm_addr      = dm_addr_q;
    assign dm_wdata     = dm_wdata_q;
    assign dm_be        = dm_be_q;
    assign wb_valid     = wb_valid_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign misalign_err = misalign_q;
    assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access: writeback path, store/load lane
// handling, misalignment, bus timeout and asynchronous reset mid-transaction.
module tb_mem_access;

    localparam int unsigned Tmo = 15;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run_in, mem_to_reg_in, we_in, re_in, reg_we_in, unsigned_in;
    logic [1:0]  bytes_in;
    logic [31:0] alu_result_in, wdata_in;
    logic [4:0]  rd_in;
    logic        stall, dm_req, dm_we, dm_ack;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic        wb_valid, misalign_err, bus_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int checks = 0;
    int errors = 0;

    mem_access #(.TIMEOUT(Tmo)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .run_in        (run_in),
        .mem_to_reg_in (mem_to_reg_in),
        .we_in         (we_in),
        .re_in         (re_in),
        .reg_we_in     (reg_we_in),
        .bytes_in      (bytes_in),
        .unsigned_in   (unsigned_in),
        .alu_result_in (alu_result_in),
        .wdata_in      (wdata_in),
        .rd_in         (rd_in),
        .stall         (stall),
        .dm_req        (dm_req),
        .dm_we         (dm_we),
        .dm_addr       (dm_addr),
        .dm_wdata      (dm_wdata),
        .dm_be         (dm_be),
        .dm_ack        (dm_ack),
        .dm_rdata      (dm_rdata),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .misalign_err  (misalign_err),
        .bus_err       (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        run_in        = 1'b0;
        mem_to_reg_in = 1'b0;
        we_in         = 1'b0;
        re_in         = 1'b0;
        reg_we_in     = 1'b0;
        bytes_in      = 2'd0;
        unsigned_in   = 1'b0;
        alu_result_in = 32'h0;
        wdata_in      = 32'h0;
        rd_in         = 5'd0;
    endtask

    task automatic issue(input logic we, input logic re, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
        run_in        = 1'b1;
        mem_to_reg_in = re;
        we_in         = we;
        re_in         = re;
        reg_we_in     = re;
        bytes_in      = sz;
        unsigned_in   = uns;
        alu_result_in = addr;
        wdata_in      = wd;
        rd_in         = rd;
    endtask

    initial begin
        logic early;
        reset_n  = 1'b0;
        dm_ack   = 1'b0;
        dm_rdata = 32'h0;
        idle_in();
        tick();
        tick();
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_dm_req", {31'd0, dm_req}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_errs", {30'd0, misalign_err, bus_err}, 32'd0);
        chk("rst_dm_be", {28'd0, dm_be}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        reset_n = 1'b1;

        // Non-memory op
        run_in = 1'b1; reg_we_in = 1'b1; rd_in = 5'd5; alu_result_in = 32'h1234;
        tick();
        chk("alu_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("alu_wb_rd", {27'd0, wb_rd}, 32'd5);
        chk("alu_wb_data", wb_data, 32'h1234);
        chk("alu_stall", {31'd0, stall}, 32'd0);
        idle_in();
        tick();
        chk("alu_wb_pulse", {31'd0, wb_valid}, 32'd0);

        // Store byte at 0x103
        issue(1'b1, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0000_00AB, 5'd0);
        tick();
        chk("sb_req", {30'd0, dm_req, dm_we}, 32'd3);
        chk("sb_be", {28'd0, dm_be}, 32'h8);
        chk("sb_wdata", dm_wdata, 32'hABAB_ABAB);
        chk("sb_addr", dm_addr, 32'h100);
        chk("sb_stall", {31'd0, stall}, 32'd1);
        idle_in();
        wdata_in = 32'h5555_5555;
        tick();
        tick();
        chk("sb_hold_req", {31'd0, dm_req}, 32'd1);
        chk("sb_hold_wdata", dm_wdata, 32'hABAB_ABAB);
        chk("sb_hold_be", {28'd0, dm_be}, 32'h8);
        dm_ack = 1'b1;
        tick();
        chk("sb_ack_req", {31'd0, dm_req}, 32'd0);
        chk("sb_resp_stall", {31'd0, stall}, 32'd1);
        chk("sb_resp_wb", {31'd0, wb_valid}, 32'd0);
        tick();
        dm_ack = 1'b0;
        chk("sb_resp_ack_ignored", {30'd0, stall, dm_req}, 32'd0);

        // Signed half load at 0x202
        issue(1'b0, 1'b1, 2'd1, 1'b0, 32'h202, 32'h0, 5'd7);
        tick();
        chk("lh_be", {28'd0, dm_be}, 32'hC);
        chk("lh_addr", dm_addr, 32'h200);
        chk("lh_req", {30'd0, dm_req, dm_we}, 32'd2);
        idle_in();
        dm_ack = 1'b1; dm_rdata = 32'h8001_0000;
        tick();
        dm_ack = 1'b0;
        chk("lh_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("lh_wb_data", wb_data, 32'hFFFF_8001);
        chk("lh_wb_rd", {27'd0, wb_rd}, 32'd7);
        tick();
        chk("lh_done", {30'd0, stall, wb_valid}, 32'd0);

        // Unsigned half load at 0x202
        issue(1'b0, 1'b1, 2'd1, 1'b1, 32'h202, 32'h0, 5'd8);
        tick();
        idle_in();
        dm_ack = 1'b1;
        tick();
        dm_ack = 1'b0;
        chk("lhu_wb_data", wb_data, 32'h0000_8001);
        tick();

        // Signed byte load at 0x001
        issue(1'b0, 1'b1, 2'd0, 1'b0, 32'h001, 32'h0, 5'd3);
        tick();
        chk("lb_be", {28'd0, dm_be}, 32'h2);
        idle_in();
        dm_ack = 1'b1; dm_rdata = 32'h0000_F000;
        tick();
        dm_ack = 1'b0;
        chk("lb_wb_data", wb_data, 32'hFFFF_FFF0);
        tick();

        // Misaligned word load at 0x301
        issue(1'b0, 1'b1, 2'd2, 1'b0, 32'h301, 32'h0, 5'd4);
        tick();
        chk("lw_mis_err", {31'd0, misalign_err}, 32'd1);
        chk("lw_mis_noreq", {30'd0, dm_req, stall}, 32'd0);
        chk("lw_mis_wb", {31'd0, wb_valid}, 32'd0);
        idle_in();
        tick();
        chk("lw_mis_pulse", {30'd0, misalign_err, dm_req}, 32'd0);

        // Illegal size
        issue(1'b1, 1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 5'd0);
        tick();
        chk("ill_mis_err", {30'd0, misalign_err, dm_req}, 32'd2);
        idle_in();

        // ack while idle is ignored
        dm_ack = 1'b1;
        tick();
        dm_ack = 1'b0;
        chk("idle_ack", {29'd0, stall, wb_valid, dm_req}, 32'd0);

        // Timeout on a word load
        issue(1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'h0, 5'd6);
        tick();
        chk("to_req", {31'd0, dm_req}, 32'd1);
        idle_in();
        early = 1'b0;
        for (int i = 1; i < Tmo; i++) begin
            tick();
            if (bus_err || !dm_req) early = 1'b1;
        end
        chk("to_not_early", {31'd0, early}, 32'd0);
        tick();
        chk("to_bus_err", {31'd0, bus_err}, 32'd1);
        chk("to_req_drop", {29'd0, dm_req, stall, wb_valid}, 32'd0);
        tick();
        chk("to_pulse", {31'd0, bus_err}, 32'd0);

        // Asynchronous reset while in REQ
        issue(1'b0, 1'b1, 2'd2, 1'b0, 32'h80, 32'h0, 5'd2);
        tick();
        chk("rr_req", {31'd0, dm_req}, 32'd1);
        idle_in();
        #2;
        reset_n = 1'b0;
        #1;
        chk("rr_async", {30'd0, dm_req, stall}, 32'd0);
        tick();
        reset_n = 1'b1;
        issue(1'b0, 1'b1, 2'd2, 1'b0, 32'h0, 32'h0, 5'd9);
        tick();
        chk("rr_lw_req", {30'd0, dm_req, stall}, 32'd3);
        chk("rr_lw_addr", dm_addr, 32'h0);
        idle_in();
        dm_ack = 1'b1; dm_rdata = 32'hDEAD_BEEF;
        tick();
        dm_ack = 1'b0;
        chk("rr_lw_valid", {31'd0, wb_valid}, 32'd1);
        chk("rr_lw_data", wb_data, 32'hDEAD_BEEF);
        chk("rr_lw_rd", {27'd0, wb_rd}, 32'd9);
        tick();
        chk("rr_lw_idle", {31'd0, stall}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
